// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN convolution and pooling/FC stages.
package snn_pkg;

    localparam int IMG_W  = 6;
    localparam int K_W    = 3;
    localparam int DW     = 8;
    localparam int Q_DIV  = 2295;
    localparam int FEAT_W = IMG_W - K_W + 1;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int NTAP   = K_W * K_W;

    typedef logic [DW-1:0]   pix_t;
    typedef logic [2*DW-1:0] prod_t;
    typedef logic [19:0]     acc_t;
    typedef logic [7:0]      feat_t;
    typedef logic [5:0]      bc_t;
    typedef logic [3:0]      idx_t;

endpackage

// File: rtl/snn_quant_div.sv
// Quantizer: floor(acc / Q_DIV). With the default parameters the quotient fits in 8 bits.
module snn_quant_div
    import snn_pkg::*;
(
    input  acc_t  acc,
    output feat_t quot
);

    // Constant-divisor division; the truncation to feat_t is safe for sums up to 585225
    always_comb begin
        quot = feat_t'(acc / acc_t'(Q_DIV));
    end

endmodule

// File: rtl/snn_conv_stage.sv
// Streaming 6x6 image / 3x3 kernel valid-mode convolution with 2-cycle pipeline
// producing a quantized 4x4 feature map as an indexed stream.
module snn_conv_stage
    import snn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] img,
    input  logic [DW-1:0] ker,
    output logic          out_valid,
    output logic [7:0]    out_feat,
    output logic [3:0]    out_idx,
    output logic          frame_done
);

    bc_t   bc_r;
    pix_t  kreg_r [NTAP];
    pix_t  pix_r  [NPIX];

    bc_t   row_s;
    bc_t   col_s;
    bc_t   base_s;
    logic  trig_s;
    idx_t  idx_s;
    pix_t  win_s;
    prod_t prod_s [NTAP];

    logic  s1_valid_r;
    idx_t  s1_idx_r;
    prod_t s1_prod_r [NTAP];

    acc_t  sum_s;
    feat_t quot_s;

    logic  out_valid_r;
    feat_t out_feat_r;
    idx_t  out_idx_r;
    logic  frame_done_r;

    // Decode beat position, window trigger, top-left tap address and feature index
    always_comb begin
        row_s  = bc_r / bc_t'(IMG_W);
        col_s  = bc_r % bc_t'(IMG_W);
        trig_s = in_valid && (row_s >= bc_t'(K_W - 1)) && (col_s >= bc_t'(K_W - 1));
        if (trig_s) begin
            base_s = bc_r - bc_t'((K_W - 1) * IMG_W + (K_W - 1));
            idx_s  = idx_t'((row_s - bc_t'(K_W - 1)) * bc_t'(FEAT_W) + (col_s - bc_t'(K_W - 1)));
        end else begin
            base_s = 6'd0;
            idx_s  = 4'd0;
        end
    end

    // Form the 9 window products; the bottom-right tap bypasses storage and uses img directly
    always_comb begin
        win_s = '0;
        for (int i = 0; i < K_W; i++) begin
            for (int j = 0; j < K_W; j++) begin
                if ((i == K_W - 1) && (j == K_W - 1)) begin
                    win_s = img;
                end else begin
                    win_s = pix_r[base_s + bc_t'(i * IMG_W + j)];
                end
                prod_s[i * K_W + j] = prod_t'(win_s) * prod_t'(kreg_r[i * K_W + j]);
            end
        end
    end

    // Beat counter: advances on valid beats only, wraps after the last pixel of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_r <= 6'd0;
        end else if (in_valid) begin
            bc_r <= (bc_r == bc_t'(NPIX - 1)) ? 6'd0 : bc_r + 6'd1;
        end else begin
            bc_r <= bc_r;
        end
    end

    // Pixel and kernel storage; the kernel is only captured on the first NTAP beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPIX; k++) pix_r[k] <= '0;
            for (int k = 0; k < NTAP; k++) kreg_r[k] <= '0;
        end else if (in_valid) begin
            pix_r[bc_r] <= img;
            if (bc_r < bc_t'(NTAP)) begin
                kreg_r[bc_r] <= ker;
            end
        end
    end

    // Stage 1: register products and index; runs every cycle regardless of in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= 4'd0;
            for (int k = 0; k < NTAP; k++) s1_prod_r[k] <= '0;
        end else begin
            s1_valid_r <= trig_s;
            s1_idx_r   <= idx_s;
            for (int k = 0; k < NTAP; k++) s1_prod_r[k] <= prod_s[k];
        end
    end

    // Adder tree over the stage-1 products
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NTAP; k++) begin
            sum_s = sum_s + acc_t'(s1_prod_r[k]);
        end
    end

    snn_quant_div u_quant_div (
        .acc  (sum_s),
        .quot (quot_s)
    );

    // Output stage: feature and index hold between valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_feat_r   <= 8'd0;
            out_idx_r    <= 4'd0;
            frame_done_r <= 1'b0;
        end else begin
            out_valid_r  <= s1_valid_r;
            frame_done_r <= s1_valid_r && (s1_idx_r == idx_t'(FEAT_W * FEAT_W - 1));
            if (s1_valid_r) begin
                out_feat_r <= quot_s;
                out_idx_r  <= s1_idx_r;
            end else begin
                out_feat_r <= out_feat_r;
                out_idx_r  <= out_idx_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_feat   = out_feat_r;
    assign out_idx    = out_idx_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_snn_conv_stage.sv
// Scoreboard bench for snn_conv_stage: directed frames push expected (idx, value, cycle)
// entries; a negedge monitor pops and compares whenever out_valid is high.
module tb_snn_conv_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] img = 8'd0;
    logic [7:0] ker = 8'd0;
    logic       out_valid;
    logic [7:0] out_feat;
    logic [3:0] out_idx;
    logic       frame_done;

    snn_conv_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .img        (img),
        .ker        (ker),
        .out_valid  (out_valid),
        .out_feat   (out_feat),
        .out_idx    (out_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int feat;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   fd_count = 0;
    bit   ignore_out = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && !ignore_out) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_idx", int'(out_idx), -1);
                end else begin
                    e = sbq.pop_front();
                    chk("out_feat", int'(out_feat), e.feat);
                    chk("out_idx", int'(out_idx), e.idx);
                    chk("out_cycle", cyc, e.cyc);
                    chk("frame_done", int'(frame_done), (e.idx == 15) ? 1 : 0);
                    if (frame_done) fd_count++;
                end
            end else begin
                chk("frame_done_idle", int'(frame_done), 0);
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        img      = 8'h5A;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ker_sel: 0 = all 255, 1 = centre-only 255, 2 = all zero
    task automatic run_frame(input bit img_ramp, input int img_val, input int ker_sel,
                             input bit exp_ramp, input int exp_val,
                             input logic [35:0] gap_after, input int last_beat);
        for (int b = 0; b <= last_beat; b++) begin
            int   row;
            int   col;
            exp_t n;
            row      = b / 6;
            col      = b % 6;
            in_valid = 1'b1;
            img      = img_ramp ? 8'(b) : 8'(img_val);
            if (b >= 9)            ker = 8'hA5;
            else if (ker_sel == 0) ker = 8'd255;
            else if (ker_sel == 1) ker = (b == 4) ? 8'd255 : 8'd0;
            else                   ker = 8'd0;
            if (row >= 2 && col >= 2 && !ignore_out) begin
                n.idx  = (row - 2) * 4 + (col - 2);
                n.feat = exp_ramp ? (6 * (row - 2) + (col - 2) + 7) : exp_val;
                n.cyc  = cyc + 2;
                sbq.push_back(n);
            end
            @(posedge clk);
            #1;
            if (gap_after[b]) begin
                in_valid = 1'b0;
                img      = 8'hC3;
                ker      = 8'h3C;
                repeat (3) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [35:0] gaps;
        gaps = 36'd0;
        gaps[4]  = 1'b1;
        gaps[15] = 1'b1;
        gaps[30] = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_feat", int'(out_feat), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        idle(2);

        // All 9 image, all 255 kernel: every output 9
        run_frame(1'b0, 9, 0, 1'b0, 9, 36'd0, 35);
        idle(4);
        // Ramp image, all 255 kernel: value = 6r+c+7
        run_frame(1'b1, 0, 0, 1'b1, 0, 36'd0, 35);
        idle(4);
        // All 255 image and kernel: 255
        run_frame(1'b0, 255, 0, 1'b0, 255, 36'd0, 35);
        idle(4);
        // All 255 image, centre-only kernel: 28
        run_frame(1'b0, 255, 1, 1'b0, 28, 36'd0, 35);
        idle(4);
        // Ramp with idle gaps after beats 4, 15, 30
        run_frame(1'b1, 0, 0, 1'b1, 0, gaps, 35);
        idle(4);
        // Back-to-back frames: 16 x 255 then 16 x 0, no gap
        run_frame(1'b0, 255, 0, 1'b0, 255, 36'd0, 35);
        run_frame(1'b0, 255, 2, 1'b0, 0, 36'd0, 35);
        idle(4);

        // Partial frame interrupted by reset after beat 20
        ignore_out = 1'b1;
        run_frame(1'b0, 9, 0, 1'b0, 9, 36'd0, 20);
        in_valid = 1'b0;
        chk("pre_rst_out_feat", int'(out_feat), 9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_feat", int'(out_feat), 0);
        chk("mid_rst_out_idx", int'(out_idx), 0);
        chk("mid_rst_frame_done", int'(frame_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ignore_out = 1'b0;
        idle(3);
        run_frame(1'b0, 9, 0, 1'b0, 9, 36'd0, 35);
        idle(1);

        // Drain with a bounded wait
        for (int w = 0; w < 20 && sbq.size() > 0; w++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        chk("frame_done_pulses", fd_count, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
